hazard_ctrl: RTL and testbench

- Hazard and pipeline-control unit for the 5-stage RISC-V pipeline; the control-side counterpart of the datapath.
- Consumes the datapath's register-address, write-enable, result-source and branch-decision outputs.
- Produces the stall, flush and forwarding-select signals the datapath consumes.
- Adds a sequential debug-halt handshake that drains the pipeline, plus optional hazard performance counters.

---
 rtl/hazard_if.sv | 45 ++++
 rtl/hazard_ctrl.sv | 160 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_if.sv
// Hazard-control bundle between the pipeline datapath and hazard_ctrl.
// The datapath side (master) drives register addresses, write enables,
// the branch decision and the debug/perf controls; the hazard unit
// (slave) drives stall, flush, forwarding selects, halt_ack and counters.
interface hazard_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       Rs1D;
    logic [4:0]       Rs2D;
    logic [4:0]       Rs1E;
    logic [4:0]       Rs2E;
    logic [4:0]       RdE;
    logic [4:0]       RdM;
    logic [4:0]       RdW;
    logic             RegWriteM;
    logic             RegWriteW;
    logic [1:0]       ResultSrcE;
    logic             PCSrcE;
    logic             halt_req;
    logic             perf_clr;

    logic             StallF;
    logic             StallD;
    logic             FlushD;
    logic             FlushE;
    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic             halt_ack;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteM, RegWriteW, ResultSrcE, PCSrcE, halt_req, perf_clr,
        input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
        input  halt_ack, stall_cnt, flush_cnt
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteM, RegWriteW, ResultSrcE, PCSrcE, halt_req, perf_clr,
        output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
        output halt_ack, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and pipeline-control unit for the 5-stage RISC-V pipeline.
// Combinational forwarding, load-use stall and branch flush, plus a
// RUN/DRAIN/HALTED debug-halt handshake that drains E->M->W before
// acknowledging. Optional hazard counters are built when the macro
// HAZARD_PERF_EN is defined; otherwise the counters read as zero.
module hazard_ctrl #(
    parameter int DRAIN_CYC = 3,
    parameter int CNT_W     = 16
) (
    input logic     clk,
    input logic     rst,
    hazard_if.slave hif
);
    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } state_t;

    state_t        state;
    logic [DW-1:0] drainCnt;
    logic          haltAck;
    logic          lwStall;
    logic [1:0]    fwdA;
    logic [1:0]    fwdB;
    logic          stallF;
    logic          stallD;
    logic          flushD;
    logic          flushE;

    // M-stage producer wins over W; x0 is never forwarded.
    function automatic logic [1:0] fwdSel(
        input logic [4:0] rs,
        input logic       wM,
        input logic [4:0] rdM,
        input logic       wW,
        input logic [4:0] rdW
    );
        if (wM && (rdM != 5'd0) && (rdM == rs))
            return 2'b10;
        else if (wW && (rdW != 5'd0) && (rdW == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // Forwarding selects and load-use detection, independent of FSM state.
    always_comb begin
        fwdA    = fwdSel(hif.Rs1E, hif.RegWriteM, hif.RdM, hif.RegWriteW, hif.RdW);
        fwdB    = fwdSel(hif.Rs2E, hif.RegWriteM, hif.RdM, hif.RegWriteW, hif.RdW);
        lwStall = (hif.ResultSrcE == 2'b01) && (hif.RdE != 5'd0) &&
                  ((hif.Rs1D == hif.RdE) || (hif.Rs2D == hif.RdE));
    end

    // Stall/flush per state; a branch in DRAIN still loads its target.
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        if (!rst) begin
            case (state)
                RUN: begin
                    stallF = lwStall;
                    stallD = lwStall;
                    flushD = hif.PCSrcE;
                    flushE = lwStall | hif.PCSrcE;
                end
                DRAIN: begin
                    stallF = !hif.PCSrcE;
                    stallD = 1'b1;
                    flushD = hif.PCSrcE;
                    flushE = 1'b1;
                end
                HALTED: begin
                    stallF = 1'b1;
                    stallD = 1'b1;
                    flushE = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Halt handshake: a taken branch defers DRAIN entry by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            drainCnt <= '0;
            haltAck  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    haltAck <= 1'b0;
                    if (hif.halt_req && !hif.PCSrcE) begin
                        state    <= DRAIN;
                        drainCnt <= DW'(DRAIN_CYC - 1);
                    end
                end
                DRAIN: begin
                    if (!hif.halt_req) begin
                        state <= RUN;
                    end else if (drainCnt == '0) begin
                        state   <= HALTED;
                        haltAck <= 1'b1;
                    end else begin
                        drainCnt <= drainCnt - 1'b1;
                    end
                end
                HALTED: begin
                    if (!hif.halt_req) begin
                        state   <= RUN;
                        haltAck <= 1'b0;
                    end
                end
                default: begin
                    state   <= RUN;
                    haltAck <= 1'b0;
                end
            endcase
        end
    end

    assign hif.StallF    = stallF;
    assign hif.StallD    = stallD;
    assign hif.FlushD    = flushD;
    assign hif.FlushE    = flushE;
    assign hif.ForwardAE = rst ? 2'b00 : fwdA;
    assign hif.ForwardBE = rst ? 2'b00 : fwdB;
    assign hif.halt_ack  = haltAck;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stallCnt;
    logic [CNT_W-1:0] flushCnt;

    // Saturating hazard counters; a clear beats an increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else if (hif.perf_clr) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if ((state == RUN) && lwStall && (stallCnt != '1))
                stallCnt <= stallCnt + 1'b1;
            if (hif.PCSrcE && (flushCnt != '1))
                flushCnt <= flushCnt + 1'b1;
        end
    end

    assign hif.stall_cnt = stallCnt;
    assign hif.flush_cnt = flushCnt;
`else
    assign hif.stall_cnt = '0;
    assign hif.flush_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    hazard_if #(.CNT_W(16)) hif ();

    hazard_ctrl #(
        .DRAIN_CYC(3),
        .CNT_W    (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hif(hif)
    );

`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]  ctl;
        logic [1:0]  fA;
        logic [1:0]  fB;
        logic        ack;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    exp_t  expQ[$];
    string tagQ[$];
    int    testsRun    = 0;
    int    testsFailed = 0;

    function automatic logic [15:0] pc(input int v);
        return PERF ? 16'(v) : 16'h0000;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        hif.Rs1D       = 5'd0;
        hif.Rs2D       = 5'd0;
        hif.Rs1E       = 5'd0;
        hif.Rs2E       = 5'd0;
        hif.RdE        = 5'd0;
        hif.RdM        = 5'd0;
        hif.RdW        = 5'd0;
        hif.RegWriteM  = 1'b0;
        hif.RegWriteW  = 1'b0;
        hif.ResultSrcE = 2'b00;
        hif.PCSrcE     = 1'b0;
        hif.halt_req   = 1'b0;
        hif.perf_clr   = 1'b0;
    endtask

    // ctl is {StallF, StallD, FlushD, FlushE}
    task automatic applyStimulus(input string tag, input logic [3:0] ctl,
                                 input logic [1:0] fA, input logic [1:0] fB,
                                 input logic ack, input int sc, input int fc);
        exp_t e;
        e.ctl = ctl;
        e.fA  = fA;
        e.fB  = fB;
        e.ack = ack;
        e.sc  = pc(sc);
        e.fc  = pc(fc);
        expQ.push_back(e);
        tagQ.push_back(tag);
    endtask

    task automatic checkOutput(input string tag, input exp_t e);
        exp_t a;
        a.ctl = {hif.StallF, hif.StallD, hif.FlushD, hif.FlushE};
        a.fA  = hif.ForwardAE;
        a.fB  = hif.ForwardBE;
        a.ack = hif.halt_ack;
        a.sc  = hif.stall_cnt;
        a.fc  = hif.flush_cnt;
        testsRun++;
        if (a !== e) begin
            testsFailed++;
            $display("[TB] FAIL %s: got ctl=%b fA=%b fB=%b ack=%b sc=%h fc=%h, want ctl=%b fA=%b fB=%b ack=%b sc=%h fc=%h",
                     tag, a.ctl, a.fA, a.fB, a.ack, a.sc, a.fc,
                     e.ctl, e.fA, e.fB, e.ack, e.sc, e.fc);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t  e;
        string t;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            t = tagQ.pop_front();
            checkOutput(t, e);
        end
    end

    initial begin : watchdog
        #1500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        clearInputs();

        // Reset holds every output low even with hazards presented
        cycle();
        hif.PCSrcE = 1'b1; hif.RegWriteM = 1'b1; hif.RdM = 5'd5; hif.Rs1E = 5'd5;
        hif.ResultSrcE = 2'b01; hif.RdE = 5'd7; hif.Rs2D = 5'd7;
        applyStimulus("inReset", 4'b0000, 2'b00, 2'b00, 1'b0, 0, 0);

        cycle(); rst = 1'b0; clearInputs();
        applyStimulus("idle", 4'b0000, 2'b00, 2'b00, 1'b0, 0, 0);

        // Forwarding priority
        cycle();
        hif.RdM = 5'd5; hif.RdW = 5'd5; hif.RegWriteM = 1'b1; hif.RegWriteW = 1'b1; hif.Rs1E = 5'd5;
        applyStimulus("fwdM", 4'b0000, 2'b10, 2'b00, 1'b0, 0, 0);
        cycle(); hif.RegWriteM = 1'b0;
        applyStimulus("fwdW", 4'b0000, 2'b01, 2'b00, 1'b0, 0, 0);
        cycle(); hif.RegWriteM = 1'b1; hif.Rs1E = 5'd0; hif.Rs2E = 5'd5;
        applyStimulus("fwdB", 4'b0000, 2'b00, 2'b10, 1'b0, 0, 0);
        cycle(); hif.RdM = 5'd0; hif.RdW = 5'd0; hif.Rs2E = 5'd0;
        applyStimulus("fwdZero", 4'b0000, 2'b00, 2'b00, 1'b0, 0, 0);

        // Load-use
        cycle(); clearInputs(); hif.ResultSrcE = 2'b01; hif.RdE = 5'd7; hif.Rs2D = 5'd7;
        applyStimulus("loadUse", 4'b1101, 2'b00, 2'b00, 1'b0, 0, 0);
        cycle(); hif.RdE = 5'd0;
        applyStimulus("loadUseR0", 4'b0000, 2'b00, 2'b00, 1'b0, 1, 0);
        cycle(); hif.RdE = 5'd3; hif.Rs1D = 5'd3; hif.Rs2D = 5'd0;
        applyStimulus("loadUseRs1", 4'b1101, 2'b00, 2'b00, 1'b0, 1, 0);
        cycle(); hif.ResultSrcE = 2'b00;
        applyStimulus("notLoad", 4'b0000, 2'b00, 2'b00, 1'b0, 2, 0);

        // Branch taken
        cycle(); clearInputs(); hif.PCSrcE = 1'b1;
        applyStimulus("branch", 4'b0011, 2'b00, 2'b00, 1'b0, 2, 0);
        cycle(); hif.PCSrcE = 1'b0;
        applyStimulus("afterBranch", 4'b0000, 2'b00, 2'b00, 1'b0, 2, 1);

        // Halt: three DRAIN cycles, ack on the fourth edge
        cycle(); hif.halt_req = 1'b1;
        applyStimulus("haltReq", 4'b0000, 2'b00, 2'b00, 1'b0, 2, 1);
        for (int i = 0; i < 3; i++) begin
            cycle();
            applyStimulus("drain", 4'b1101, 2'b00, 2'b00, 1'b0, 2, 1);
        end
        cycle(); hif.RegWriteM = 1'b1; hif.RdM = 5'd9; hif.Rs1E = 5'd9;
        applyStimulus("halted", 4'b1101, 2'b10, 2'b00, 1'b1, 2, 1);
        cycle();
        applyStimulus("haltedHold", 4'b1101, 2'b10, 2'b00, 1'b1, 2, 1);
        cycle(); hif.halt_req = 1'b0;
        applyStimulus("releaseReq", 4'b1101, 2'b10, 2'b00, 1'b1, 2, 1);
        cycle(); clearInputs();
        applyStimulus("runAgain", 4'b0000, 2'b00, 2'b00, 1'b0, 2, 1);

        // Halt coinciding with a taken branch
        cycle(); hif.halt_req = 1'b1; hif.PCSrcE = 1'b1;
        applyStimulus("haltBranch", 4'b0011, 2'b00, 2'b00, 1'b0, 2, 1);
        cycle(); hif.PCSrcE = 1'b0;
        applyStimulus("haltDeferred", 4'b0000, 2'b00, 2'b00, 1'b0, 2, 2);
        for (int i = 0; i < 3; i++) begin
            cycle();
            applyStimulus("drainB", 4'b1101, 2'b00, 2'b00, 1'b0, 2, 2);
        end
        cycle();
        applyStimulus("haltedB", 4'b1101, 2'b00, 2'b00, 1'b1, 2, 2);

        // Asynchronous reset while HALTED
        cycle(); rst = 1'b1; hif.RegWriteM = 1'b1; hif.RdM = 5'd4; hif.Rs1E = 5'd4;
        applyStimulus("resetHalted", 4'b0000, 2'b00, 2'b00, 1'b0, 0, 0);
        cycle(); rst = 1'b0; clearInputs();
        applyStimulus("afterReset", 4'b0000, 2'b00, 2'b00, 1'b0, 0, 0);

        // Branch in first DRAIN cycle, then abort by dropping halt_req
        cycle(); hif.halt_req = 1'b1;
        applyStimulus("haltAgain", 4'b0000, 2'b00, 2'b00, 1'b0, 0, 0);
        cycle(); hif.PCSrcE = 1'b1;
        applyStimulus("drainBranch", 4'b0111, 2'b00, 2'b00, 1'b0, 0, 0);
        cycle(); hif.PCSrcE = 1'b0; hif.halt_req = 1'b0;
        applyStimulus("drainAbort", 4'b1101, 2'b00, 2'b00, 1'b0, 0, 1);
        cycle();
        applyStimulus("runAfterAbort", 4'b0000, 2'b00, 2'b00, 1'b0, 0, 1);

        // Clear beats simultaneous increments
        cycle(); hif.PCSrcE = 1'b1; hif.perf_clr = 1'b1;
        hif.ResultSrcE = 2'b01; hif.RdE = 5'd7; hif.Rs2D = 5'd7;
        applyStimulus("perfClr", 4'b1111, 2'b00, 2'b00, 1'b0, 0, 1);
        cycle(); clearInputs();
        applyStimulus("cleared", 4'b0000, 2'b00, 2'b00, 1'b0, 0, 0);

`ifdef HAZARD_PERF_EN
        // Saturation of the stall counter
        cycle(); hif.ResultSrcE = 2'b01; hif.RdE = 5'd7; hif.Rs2D = 5'd7;
        repeat (65540) cycle();
        applyStimulus("stallSat", 4'b1101, 2'b00, 2'b00, 1'b0, 65535, 0);
        cycle(); clearInputs();
        applyStimulus("satHold", 4'b0000, 2'b00, 2'b00, 1'b0, 65535, 0);
`endif

        for (int i = 0; i < 10 && expQ.size() > 0; i++) cycle();
        if (expQ.size() > 0) begin
            testsFailed++;
            $display("[TB] FAIL drain: %0d expectations left, want 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
